// File: rtl/ps2_mouse_tx.sv
// ps2_mouse_tx: PS/2 device-side transmitter sending 3-byte mouse packets over open-drain clock/data lines.
module ps2_mouse_tx #(
  parameter int CLK_HALF = 2500,
  parameter int BYTE_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] x_move,
  input  logic [8:0] y_move,
  input  logic       x_ovf,
  input  logic       y_ovf,
  input  logic [2:0] btn,
  input  logic       send,
  output logic       ready,
  output logic       done,
  output logic       abort,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int MAXC = (BYTE_GAP * CLK_HALF > CLK_HALF) ? BYTE_GAP * CLK_HALF : CLK_HALF;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(BYTE_GAP * CLK_HALF - 1);
  typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, GAP, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n;
  logic [23:0] pkt;
  logic [1:0] clk_sync, data_sync;
  logic [7:0] cur;
  logic [10:0] frame;
  logic bus_idle, last, clk_oe_n, data_oe_n, abort_n;
  assign bus_idle = clk_sync[1] & data_sync[1];
  assign last = cnt == '0;
  assign cur = byte_n == 2'd0 ? pkt[7:0] : byte_n == 2'd1 ? pkt[15:8] : pkt[23:16];
  assign frame = {1'b1, ~^cur, cur, 1'b0};
  assign ready = state == IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    bit_n = bit_idx;
    byte_n = byte_idx;
    abort_n = 1'b0;
    case (state)
      IDLE: if (send) begin
        state_n = WAIT_BUS;
        bit_n = '0;
        byte_n = '0;
      end
      WAIT_BUS: if (bus_idle && last) state_n = BIT_HIGH;
      // the host may inhibit up to the parity bit; the stop bit is already committed
      BIT_HIGH: if (last) begin
        if (bit_idx <= 4'd9 && !clk_sync[1]) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else state_n = BIT_LOW;
      end
      BIT_LOW: if (last) begin
        if (bit_idx == 4'd10) state_n = GAP;
        else begin
          state_n = BIT_HIGH;
          bit_n = bit_idx + 1'b1;
        end
      end
      GAP: if (last) begin
        if (byte_idx == 2'd2) state_n = DONE;
        else begin
          state_n = WAIT_BUS;
          bit_n = '0;
          byte_n = byte_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // reload on every state change so each phase is timed from its own entry
    cnt_n = (state_n == IDLE || state_n == DONE) ? '0 :
            state_n != state ? (state_n == GAP ? GAP_M1 : HALF_M1) :
            (state == WAIT_BUS && !bus_idle) ? HALF_M1 : cnt - 1'b1;
    clk_oe_n = state_n == BIT_LOW;
    data_oe_n = (state_n == BIT_HIGH || state_n == BIT_LOW) && !frame[bit_n];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      pkt <= '0;
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      clk_sync <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      abort <= abort_n;
      if (state == IDLE && send)
        pkt <= {y_move[7:0], x_move[7:0], y_ovf, x_ovf, y_move[8], x_move[8], 1'b1, btn};
    end
  end
endmodule
